// File: rtl/fpf_pkg.sv
// Shared types and helpers for the flattened-priority iSLIP scheduler.
package fpf_pkg;

  localparam int unsigned FPF_N     = 25;
  localparam int unsigned FPF_P     = 8;
  localparam int unsigned FPF_LW    = 8;
  // Widest vector onehot_to_idx can decode; N and P must not exceed it.
  localparam int unsigned FPF_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY
  } fpf_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [FPF_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < FPF_MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
  import fpf_pkg::*;
#(
  parameter int unsigned N  = FPF_N,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] first;

  // Lower half holds requests at/after ptr, upper half the full set for the
  // wrap case; the lowest set bit of the double vector is the winner.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    dbl   = {req, req & mask};
    first = dbl & (-dbl);
    grant = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/select_grant.sv
// Output-side grant stage: picks highest requested priority, round-robins
// within it, presents the grant, then holds the port busy for the packet.
// Optional: define FPF_INPUT_MASK_EN to add i_matched, which removes already
// matched inputs from arbitration.
module select_grant
  import fpf_pkg::*;
#(
  parameter int unsigned N  = FPF_N,
  parameter int unsigned P  = FPF_P,
  parameter int unsigned LW = FPF_LW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*P-1:0] i_request,
`ifdef FPF_INPUT_MASK_EN
  input  logic [N-1:0]   i_matched,
`endif
  input  logic           i_start,
  input  logic           i_accept,
  input  logic [LW-1:0]  i_len,
  output logic [N-1:0]   o_grant,
  output logic [P-1:0]   o_priority,
  output logic           o_valid,
  output logic           o_busy
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned PW = idx_w(P);

  fpf_state_t state_q, state_d;

  logic [IW-1:0]        ptr_q [P];
  logic [LW-1:0]        cnt_q;
  logic [N*P-1:0]       req_eff;
  logic [P-1:0]         level_any;
  logic [P-1:0]         lvl_onehot;
  logic [PW-1:0]        lvl_c;
  logic [N-1:0]         lvl_req;
  logic [N-1:0]         grant_c;
  logic                 any_req;
  logic [FPF_MAX_W-1:0] grant_ext;
  logic [FPF_MAX_W-1:0] prio_ext;
  logic [IW-1:0]        gnt_idx;
  logic [PW-1:0]        gnt_lvl;

  // Eligible requests (matched inputs dropped when masking is built in).
  always_comb begin
    req_eff = i_request;
`ifdef FPF_INPUT_MASK_EN
    for (int unsigned i = 0; i < N; i++) begin
      if (i_matched[i]) req_eff[i*P +: P] = '0;
    end
`endif
  end

  // Highest requested level and the per-input request vector at that level.
  always_comb begin
    level_any = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < P; j++) begin
        level_any[j] = level_any[j] | req_eff[i*P+j];
      end
    end
    any_req = |level_any;
    lvl_c   = '0;
    for (int unsigned j = 0; j < P; j++) begin
      if (level_any[j]) lvl_c = PW'(j);
    end
    lvl_onehot = '0;
    if (any_req) lvl_onehot[lvl_c] = 1'b1;
    lvl_req = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lvl_req[i] = req_eff[i*P + 32'(lvl_c)];
    end
  end

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .req   (lvl_req),
    .ptr   (ptr_q[lvl_c]),
    .grant (grant_c)
  );

  // Pointer update uses the registered grant, since requests may have moved
  // on by the time the accept arrives.
  always_comb begin
    grant_ext          = '0;
    grant_ext[N-1:0]   = o_grant;
    prio_ext           = '0;
    prio_ext[P-1:0]    = o_priority;
    gnt_idx            = IW'(onehot_to_idx(grant_ext));
    gnt_lvl            = PW'(onehot_to_idx(prio_ext));
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_d = state_q;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && any_req) state_d = GRANT;
      end
      GRANT: begin
        o_valid = 1'b1;
        state_d = i_accept ? BUSY : IDLE;
      end
      BUSY: begin
        o_busy = 1'b1;
        if (cnt_q == LW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant registers, per-level pointers and packet-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_grant    <= '0;
      o_priority <= '0;
      cnt_q      <= '0;
      for (int unsigned j = 0; j < P; j++) begin
        ptr_q[j] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start && any_req) begin
            o_grant    <= grant_c;
            o_priority <= lvl_onehot;
          end
        end
        GRANT: begin
          if (i_accept) begin
            ptr_q[gnt_lvl] <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
            cnt_q          <= (i_len == '0) ? LW'(1) : i_len;
          end else begin
            o_grant    <= '0;
            o_priority <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            o_grant    <= '0;
            o_priority <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_select_grant.sv
// Directed bench for select_grant at N=4, P=4.
module tb_select_grant;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned LW = 8;

  logic           clk;
  logic           reset;
  logic [N*P-1:0] i_request;
  logic [N-1:0]   i_matched;
  logic           i_start;
  logic           i_accept;
  logic [LW-1:0]  i_len;
  logic [N-1:0]   o_grant;
  logic [P-1:0]   o_priority;
  logic           o_valid;
  logic           o_busy;

  int vectors;
  int miscompares;
  bit mon_en;

  select_grant #(
    .N  (N),
    .P  (P),
    .LW (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_request  (i_request),
`ifdef FPF_INPUT_MASK_EN
    .i_matched  (i_matched),
`endif
    .i_start    (i_start),
    .i_accept   (i_accept),
    .i_len      (i_len),
    .o_grant    (o_grant),
    .o_priority (o_priority),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Structural invariants on every negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if ((o_valid === 1'b1 && o_busy === 1'b1) ||
          ((o_valid === 1'b1 || o_busy === 1'b1) ? !$onehot(o_grant) : (o_grant !== '0))) begin
        miscompares++;
        $display("FAIL invariant: got valid=%b busy=%b grant=%b expected exclusive flags and legal grant",
                 o_valid, o_busy, o_grant);
      end
    end
  end

  function automatic logic [N*P-1:0] rq(input int unsigned i, input int unsigned j);
    logic [N*P-1:0] r;
    r = '0;
    r[i*P+j] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    i_request = '0;
    i_matched = '0;
    i_start   = 1'b0;
    i_accept  = 1'b0;
    i_len     = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_round(input logic [N*P-1:0] req, output logic [N-1:0] g,
                             output logic [P-1:0] p, output logic v);
    i_request = req;
    i_start   = 1'b1;
    tick();
    g = o_grant;
    p = o_priority;
    v = o_valid;
    i_start = 1'b0;
  endtask

  task automatic accept_round(input logic [LW-1:0] len);
    i_accept = 1'b1;
    i_len    = len;
    tick();
    i_accept = 1'b0;
    i_len    = '0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic full_round(input logic [N*P-1:0] req, input logic [LW-1:0] len,
                            output logic [N-1:0] g);
    logic [P-1:0] p;
    logic v;
    int n;
    start_round(req, g, p, v);
    accept_round(len);
    measure_busy(n);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
  endtask

  task automatic test_basic_grant();
    logic [N-1:0] g;
    logic [P-1:0] p;
    logic v;
    int n;
    do_reset();
    start_round(rq(0, 1) | rq(2, 3), g, p, v);
    vectors++;
    if ({v, o_busy, g, p} !== {1'b1, 1'b0, 4'b0100, 4'b1000}) begin
      miscompares++;
      $display("FAIL basic_grant: got valid=%b busy=%b grant=%b pri=%b expected 1 0 0100 1000",
               v, o_busy, g, p);
    end
    accept_round(8'd3);
    vectors++;
    if ({o_valid, o_busy, o_grant, o_priority} !== {1'b0, 1'b1, 4'b0100, 4'b1000}) begin
      miscompares++;
      $display("FAIL basic_busy_hold: got valid=%b busy=%b grant=%b pri=%b expected 0 1 0100 1000",
               o_valid, o_busy, o_grant, o_priority);
    end
    measure_busy(n);
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL basic_busy_len: got %0d cycles expected 3", n);
    end
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL basic_release: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g;
    logic [N-1:0] exp_g [4];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b1000;
    exp_g[3] = 4'b0001;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      full_round(rq(0, 2) | rq(1, 2) | rq(3, 2), 8'd1, g);
      vectors++;
      if (g !== exp_g[r]) begin
        miscompares++;
        $display("FAIL rr_round%0d: got %b expected %b", r, g, exp_g[r]);
      end
    end
  endtask

  task automatic test_reject();
    logic [N-1:0] g;
    logic [P-1:0] p;
    logic v;
    do_reset();
    start_round(rq(1, 0) | rq(2, 0), g, p, v);
    vectors++;
    if ({g, p} !== {4'b0010, 4'b0001}) begin
      miscompares++;
      $display("FAIL reject_first: got grant=%b pri=%b expected 0010 0001", g, p);
    end
    tick();
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL reject_idle: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
    start_round(rq(1, 0) | rq(2, 0), g, p, v);
    vectors++;
    if (g !== 4'b0010) begin
      miscompares++;
      $display("FAIL reject_repeat: got %b expected 0010", g);
    end
    tick();
  endtask

  task automatic test_level_isolation();
    logic [N-1:0] g;
    do_reset();
    full_round(rq(2, 3), 8'd1, g);
    full_round(rq(0, 0) | rq(2, 0), 8'd1, g);
    vectors++;
    if (g !== 4'b0001) begin
      miscompares++;
      $display("FAIL isolation_pri0: got %b expected 0001", g);
    end
    full_round(rq(0, 3) | rq(2, 3) | rq(3, 3), 8'd1, g);
    vectors++;
    if (g !== 4'b1000) begin
      miscompares++;
      $display("FAIL isolation_pri3: got %b expected 1000", g);
    end
  endtask

  task automatic test_len_boundaries();
    logic [N-1:0] g;
    logic [P-1:0] p;
    logic v;
    int n;
    logic [LW-1:0] lens [3];
    int exp_n [3];
    lens[0] = 8'd0; exp_n[0] = 1;
    lens[1] = 8'd1; exp_n[1] = 1;
    lens[2] = 8'd5; exp_n[2] = 5;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      start_round(rq(1, 1), g, p, v);
      accept_round(lens[k]);
      measure_busy(n);
      vectors++;
      if (n != exp_n[k]) begin
        miscompares++;
        $display("FAIL len_%0d: got %0d busy cycles expected %0d", lens[k], n, exp_n[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] g;
    do_reset();
    full_round(rq(3, 0), 8'd1, g);
    full_round(rq(0, 0) | rq(3, 0), 8'd1, g);
    vectors++;
    if (g !== 4'b0001) begin
      miscompares++;
      $display("FAIL ptr_wrap: got %b expected 0001", g);
    end
  endtask

  task automatic test_no_request();
    do_reset();
    i_request = '0;
    i_start   = 1'b1;
    tick();
    tick();
    i_start = 1'b0;
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL no_request: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    i_request = rq(0, 1);
    i_start   = 1'b1;
    tick();
    i_accept = 1'b1;
    i_len    = 8'd4;
    tick();
    i_request = rq(3, 3);
    i_len     = 8'd9;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({o_valid, o_busy, o_grant, o_priority} !== {1'b0, 1'b1, 4'b0001, 4'b0010}) begin
        miscompares++;
        $display("FAIL ignore_busy%0d: got valid=%b busy=%b grant=%b pri=%b expected 0 1 0001 0010",
                 c, o_valid, o_busy, o_grant, o_priority);
      end
      if (c == 1) begin
        i_start  = 1'b0;
        i_accept = 1'b0;
      end
      tick();
    end
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_last_busy: got busy=%b expected 1", o_busy);
    end
    tick();
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL ignore_release: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
  endtask

  task automatic test_reset_in_busy();
    logic [N-1:0] g;
    logic [P-1:0] p;
    logic v;
    do_reset();
    start_round(rq(1, 2) | rq(2, 2), g, p, v);
    accept_round(8'd8);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({o_grant, o_priority, o_valid, o_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_busy_outputs: got grant=%b pri=%b valid=%b busy=%b expected all zero",
               o_grant, o_priority, o_valid, o_busy);
    end
    reset = 1'b0;
    start_round(rq(1, 2) | rq(2, 2), g, p, v);
    vectors++;
    if (g !== 4'b0010) begin
      miscompares++;
      $display("FAIL reset_busy_ptr: got %b expected 0010", g);
    end
    tick();
  endtask

`ifdef FPF_INPUT_MASK_EN
  task automatic test_mask();
    logic [N-1:0] g;
    logic [P-1:0] p;
    logic v;
    do_reset();
    i_matched = 4'b0100;
    start_round(rq(0, 1) | rq(2, 3), g, p, v);
    vectors++;
    if ({g, p} !== {4'b0001, 4'b0010}) begin
      miscompares++;
      $display("FAIL mask_grant: got grant=%b pri=%b expected 0001 0010", g, p);
    end
    tick();
    i_matched = '0;
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_basic_grant();
    test_round_robin();
    test_reject();
    test_level_isolation();
    test_len_boundaries();
    test_wrap();
    test_no_request();
    test_ignored_inputs();
    test_reset_in_busy();
`ifdef FPF_INPUT_MASK_EN
    test_mask();
`endif
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/select_grant.md
Name: select_grant

Overview:
Output-side grant stage of the flattened-priority iSLIP switch scheduler, directly upstream of the accept stage. There is one instance per output port.
- Collects per-input priority requests.
- Picks the highest requested priority level, then round-robins among inputs at that level using one pointer per level.
- Presents a one-hot grant plus its priority to the accept stage.
- Holds the output busy for the packet length once the grant is accepted.

Parameters:
N, 25, number of input ports (requesters)
P, 8, number of priority levels; bit P-1 is the highest priority
LW, 8, width of packet-length counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_request  input  N*P  bit i*P+j = input i requests at priority j; at most one bit per input
i_start  input  1  pulse: begin arbitration round (sampled only in IDLE)
i_accept  input  1  accept stage accepted this port's grant (sampled only in GRANT)
i_len  input  LW  packet length in cycles for the accepted transfer (sampled with i_accept)
o_grant  output  N  one-hot granted input, registered
o_priority  output  P  one-hot priority of the grant, registered
o_valid  output  1  o_grant/o_priority valid (state GRANT)
o_busy  output  1  output port occupied (state BUSY)

Behaviour:
- Reset: state IDLE; o_grant=0, o_priority=0, o_valid=0, o_busy=0; all pointers ptr[j]=0; counter=0.
- Level select: lvl = highest j with any i_request[i*P+j]=1.
- Round-robin within lvl: grant the first input k with a request at lvl, searching k = ptr[lvl], ptr[lvl]+1, … N-1, 0, … ptr[lvl]-1.
- FSM:
  - IDLE: if i_start and any request, register o_grant/o_priority and go to GRANT next cycle (1-cycle latency). If i_start with no request, stay in IDLE; outputs stay 0.
  - GRANT: o_valid=1 for exactly one cycle.
    - If i_accept: ptr[lvl] <= k+1, wrapping N-1 to 0. Only the granted level's pointer changes. Load counter with i_len (value 0 is treated as 1). Go to BUSY.
    - Else: pointers unchanged; clear o_grant/o_priority; go to IDLE.
  - BUSY: o_busy=1; o_grant/o_priority are held. Counter decrements each cycle. When the counter equals 1, clear outputs and go to IDLE next cycle. BUSY lasts exactly max(i_len,1) cycles.
- Input handling outside the sampling states:
  - i_start in GRANT or BUSY is ignored.
  - i_accept outside GRANT is ignored.
  - Request changes during GRANT or BUSY do not alter registered outputs.
- Reset mid-operation (any state): returns to the reset values above at the next edge. Pointers also return to 0.
- Invariant: o_valid and o_busy are never both 1.
- Invariant: o_grant is one-hot whenever o_valid or o_busy is 1, and zero otherwise.

Optional Feature:
Macro FPF_INPUT_MASK_EN.
- Defined: adds port i_matched (input, N). Inputs with i_matched[i]=1 are removed from requests before level select, so they cannot set lvl. This supports multi-iteration matching.
- Undefined: port absent; all requests eligible.

Decomposition:
- Shared package fpf_pkg:
  - default N/P constants;
  - idx_w(N) = $clog2(N) function;
  - state enum {IDLE, GRANT, BUSY};
  - one-hot to index function.
- Sub-module rr_arbiter (N-bit request, pointer input, one-hot grant out, purely combinational double-width mask technique). It is instantiated once, on the requests of the selected level, with pointer ptr[lvl].

Test Plan:
- Basic grant (N=4, P=4): in0@pri1 and in2@pri3, i_start → GRANT with o_grant=0100, o_priority=1000; i_accept, i_len=3 → o_busy for 3 cycles, ptr[3]=3.
- Round-robin fairness: in0,in1,in3 all @pri2; 3 accepted rounds → grants in0, in1, in3 in that order, then in0; ptr[2] sequence 1,2,0,1.
- Reject path: grant in1@pri0, i_accept=0 → IDLE next cycle, ptr[0] unchanged; repeat round → in1 again.
- Per-level pointer isolation: accept in2@pri3 (ptr[3]=3), then only pri0 requests in0,in2 → in0 granted (ptr[0]=0 unaffected).
- Boundaries:
  - i_len=0 → BUSY exactly 1 cycle.
  - Pointer wrap: accept in3 with N=4 → ptr=0.
  - i_start with no requests → stays IDLE, outputs 0.
- Reset in BUSY (counter=5) → next cycle all outputs 0, ptrs 0.
- With FPF_INPUT_MASK_EN: i_matched=0100 masks in2@pri3 → in0@pri1 granted, o_priority=0010.
